// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   det_state_e : observable detector state (coverage and assertions only)
//   DEF_*       : configuration loaded at reset (the classic "101" detector)
package seq_det_pkg;

    // state    | meaning
    // ST_IDLE  | detector was disabled in the last cycle, everything held
    // ST_FILL  | fewer than len-1 history bits, next bit cannot complete a match
    // ST_ARMED | at least len-1 history bits, next bit may complete a match
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } det_state_e;

    localparam logic [31:0] DEF_PATTERN = 32'b101;
    localparam int          DEF_LEN     = 3;
    localparam bit          DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : count up by one (holds at all-ones)
//   clr_i      : clear; when coincident with inc_i the result is 1
//   cnt_o      : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            // the event that arrives with the clear is not lost
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-stream pattern detector with programmable pattern, length and
// overlap mode. Output flag and counters are registered (Moore style).
//   clk, reset_n         : clock, asynchronous active-low reset
//   enable               : when low, incoming bits are ignored and state held
//   in_valid, x          : serial bit and its strobe
//   cfg_load             : load cfg_pattern/cfg_len/cfg_overlap (wins over in_valid)
//   cfg_pattern          : pattern, bit [len-1] oldest, bit [0] newest
//   cfg_len, cfg_overlap : pattern length (1..MAX_LEN), overlapping matches allowed
//   count_clr            : synchronous clear of match_count
//   y                    : one-cycle pulse per match
//   match_count          : saturating match counter
//   cfg_err              : one-cycle pulse when a load is rejected
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
    parameter int                 DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter bit                 DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    import seq_det_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] window_q,  window_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;
    logic               y_q,       y_d;
    logic               cfg_err_q, cfg_err_d;
    det_state_e         state_q,   state_d;

    logic               accept;
    logic               cfg_ok;
    logic               hit;
    logic [MAX_LEN-1:0] win_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic               pat_eq;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W:0]     fill_p1;
    logic [LEN_W:0]     fill_d_p1;

    assign accept    = enable && in_valid && !cfg_load;
    assign cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    assign win_shift = {window_q[MAX_LEN-2:0], x};

    // shifting by len == MAX_LEN yields zero, so the mask becomes all ones
    assign len_mask  = ~({MAX_LEN{1'b1}} << len_q);
    assign pat_eq    = ((win_shift ^ pattern_q) & len_mask) == '0;

    assign fill_inc  = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);

    // one extra bit so fill+1 cannot wrap when MAX_LEN+1 is a power of two
    assign fill_p1   = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_d_p1 = {1'b0, fill_d} + {{LEN_W{1'b0}}, 1'b1};

    assign hit       = accept && (fill_p1 >= {1'b0, len_q}) && pat_eq;

    always_comb begin
        window_d  = window_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        y_d       = 1'b0;
        cfg_err_d = 1'b0;

        if (cfg_load) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                window_d  = '0;
                fill_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (accept) begin
            window_d = win_shift;
            y_d      = hit;
            // non-overlap: the next match must be built from len fresh bits
            fill_d   = (hit && !overlap_q) ? '0 : fill_inc;
        end

        if (!enable) begin
            state_d = ST_IDLE;
        end else if (fill_d_p1 >= {1'b0, len_d}) begin
            state_d = ST_ARMED;
        end else begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_q  <= '0;
            fill_q    <= '0;
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            y_q       <= 1'b0;
            cfg_err_q <= 1'b0;
            state_q   <= ST_FILL;
        end else begin
            window_q  <= window_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            y_q       <= y_d;
            cfg_err_q <= cfg_err_d;
            state_q   <= state_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc_i (hit),
        .clr_i (count_clr),
        .cnt_o (match_count)
    );

    assign y       = y_q;
    assign cfg_err = cfg_err_q;

    a_fill_range : assert property (@(posedge clk) disable iff (!reset_n)
        fill_q <= MAX_LEN_L);

    a_len_range : assert property (@(posedge clk) disable iff (!reset_n)
        (len_q != '0) && (len_q <= MAX_LEN_L));

    a_armed_fill : assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == ST_ARMED) |-> (fill_p1 >= {1'b0, len_q}));

    a_fill_state : assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == ST_FILL) |-> (fill_p1 < {1'b0, len_q}));

    a_y_err_excl : assert property (@(posedge clk) disable iff (!reset_n)
        !(y_q && cfg_err_q));

    c_armed : cover property (@(posedge clk) disable iff (!reset_n)
        state_q == ST_ARMED);

    c_idle : cover property (@(posedge clk) disable iff (!reset_n)
        state_q == ST_IDLE);

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         in_valid = 1'b0;
    logic         x = 1'b0;
    logic         cfg_load = 1'b0;
    logic [7:0]   cfg_pattern = '0;
    logic [3:0]   cfg_len = '0;
    logic         cfg_overlap = 1'b0;
    logic         count_clr = 1'b0;

    logic         y, cfg_err;
    logic [15:0]  match_count;
    logic         y2, cfg_err2;
    logic [1:0]   mc2;

    int n_checks = 0;
    int n_fail   = 0;
    int y_pulses = 0;
    int p0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid), .x(x),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .y(y), .match_count(match_count), .cfg_err(cfg_err));

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid), .x(x),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .y(y2), .match_count(mc2), .cfg_err(cfg_err2));

    // ---------------- behavioural reference model ----------------
    bit         hist[$];
    int         since = 0;
    logic [7:0] m_pat = 8'b101;
    int         m_len = 3;
    bit         m_ovl = 1'b1;
    int         exp_y = 0, exp_err = 0, exp_cnt = 0, exp_cnt2 = 0;
    bit         m_hit, m_match;

    task automatic model_reset();
        hist.delete();
        since    = 0;
        m_pat    = 8'b101;
        m_len    = 3;
        m_ovl    = 1'b1;
        exp_y    = 0;
        exp_err  = 0;
        exp_cnt  = 0;
        exp_cnt2 = 0;
    endtask

    function automatic int sat_next(input int c, input bit h, input bit clr, input int maxv);
        if (clr) return h ? 1 : 0;
        if (h) return (c + 1 > maxv) ? maxv : c + 1;
        return c;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            m_hit   = 1'b0;
            exp_y   = 0;
            exp_err = 0;
            if (cfg_load) begin
                if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
                    m_pat = cfg_pattern;
                    m_len = cfg_len;
                    m_ovl = cfg_overlap;
                    hist.delete();
                    since = 0;
                end else begin
                    exp_err = 1;
                end
            end else if (enable && in_valid) begin
                hist.push_back(x);
                if (hist.size() > 64) void'(hist.pop_front());
                since++;
                if (since >= m_len) begin
                    m_match = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (hist[hist.size() - 1 - k] != m_pat[k]) m_match = 1'b0;
                    m_hit = m_match;
                end
                if (m_hit && !m_ovl) since = 0;
                exp_y = m_hit;
            end
            exp_cnt  = sat_next(exp_cnt,  m_hit, count_clr, 65535);
            exp_cnt2 = sat_next(exp_cnt2, m_hit, count_clr, 3);
        end
    end

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        check("y",               y,           exp_y);
        check("cfg_err",         cfg_err,     exp_err);
        check("match_count",     match_count, exp_cnt);
        check("y_cnt2",          y2,          exp_y);
        check("cfg_err_cnt2",    cfg_err2,    exp_err);
        check("match_count_sat", mc2,         exp_cnt2);
        if (y) y_pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit en, input bit v, input bit b, input bit clr);
        @(negedge clk);
        enable    = en;
        in_valid  = v;
        x         = b;
        cfg_load  = 1'b0;
        count_clr = clr;
    endtask

    task automatic bitin(input bit b);
        cyc(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input int n, input logic [31:0] v);
        for (int i = n - 1; i >= 0; i--) bitin(v[i]);
    endtask

    // in_valid=1 alongside the load: that bit must be dropped
    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o, input bit clr);
        @(negedge clk);
        enable      = 1'b1;
        in_valid    = 1'b1;
        x           = 1'b1;
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        count_clr   = clr;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        count_clr = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] pat_a5;

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_y",     y,           0);
        check("reset_count", match_count, 0);
        check("reset_err",   cfg_err,     0);
        reset_n = 1'b1;
        idle(2);

        // 1: default 101, overlap
        p0 = y_pulses;
        send(5, 32'b10101);
        idle(3);
        check("t1_pulses",      y_pulses - p0, 2);
        check("t1_count",       match_count,   2);
        check("t1_model_count", exp_cnt,       2);

        // 2: 101 non-overlap, counter cleared together with the load
        load(8'b101, 4'd3, 1'b0, 1'b1);
        idle(1);
        check("t2_count_cleared", match_count, 0);
        p0 = y_pulses;
        send(5, 32'b10101);
        idle(3);
        check("t2_pulses",      y_pulses - p0, 1);
        check("t2_count",       match_count,   1);
        check("t2_model_count", exp_cnt,       1);

        // 3: len 8, 0xA5 with 2-cycle gaps
        load(8'hA5, 4'd8, 1'b1, 1'b0);
        idle(1);
        p0 = y_pulses;
        pat_a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            bitin(pat_a5[i]);
            if (i > 0) idle(2);
        end
        idle(1);
        check("t3_y_after_last", y, 1);
        idle(2);
        check("t3_pulses", y_pulses - p0, 1);
        check("t3_count",  match_count,   2);

        // 4: rejected loads keep the old config
        load(8'b101, 4'd3, 1'b1, 1'b0);
        idle(1);
        load(8'hFF, 4'd0, 1'b0, 1'b0);
        idle(1);
        check("t4_err_len0", cfg_err, 1);
        load(8'hFF, 4'd9, 1'b0, 1'b0);
        idle(1);
        check("t4_err_len9", cfg_err, 1);
        idle(1);
        check("t4_err_clear", cfg_err, 0);
        p0 = y_pulses;
        send(3, 32'b101);
        idle(3);
        check("t4_pulses", y_pulses - p0, 1);
        check("t4_count",  match_count,   3);

        // 5: len 1, saturation of the 2-bit counter, clear with hit
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        load(8'h01, 4'd1, 1'b1, 1'b0);
        idle(1);
        check("t5_sat_cleared", mc2, 0);
        p0 = y_pulses;
        repeat (6) bitin(1'b1);
        idle(1);
        check("t5_sat",       mc2,         3);
        check("t5_model_sat", exp_cnt2,    3);
        check("t5_main",      match_count, 6);
        idle(1);
        check("t5_pulses", y_pulses - p0, 6);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);
        check("t5_clr_hit_sat",  mc2,         1);
        check("t5_clr_hit_main", match_count, 1);

        // 6: reset mid-pattern, then enable hold
        load(8'b101, 4'd3, 1'b1, 1'b0);
        idle(2);
        p0 = y_pulses;
        bitin(1'b1);
        bitin(1'b0);
        pulse_reset();
        idle(2);
        check("t6_no_pulse",   y_pulses - p0, 0);
        check("t6_reset_count", match_count,  0);
        send(3, 32'b101);
        idle(3);
        check("t6_after_reset", y_pulses - p0, 1);
        p0 = y_pulses;
        bitin(1'b1);
        bitin(1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        bitin(1'b1);
        idle(3);
        check("t6_enable_hold", y_pulses - p0, 1);
        check("t6_count",       match_count,   2);

        // random phase, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset_n     = 1'b1;
            enable      = ($urandom_range(0, 9) != 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            x           = 1'($urandom_range(0, 1));
            count_clr   = ($urandom_range(0, 99) == 0);
            cfg_load    = ($urandom_range(0, 49) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 3));
            cfg_overlap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) #2 reset_n = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
